ddr_rd_return: RTL and testbench

- Read-return stage directly downstream of the SDR/DDR data path.
- Captures each read beat the data path presents on u_data_o/u_data_valid and buffers it in a FIFO.
- Tags the final beat of every read request using a queue of issued-command lengths.
- Delivers beats to the host over a valid/ready interface, and reports free space so the controller can throttle read issue.

---
 rtl/ddr_rd_pkg.sv | 41 ++++
 rtl/sync_fifo.sv | 54 +++++
 rtl/ddr_rd_return.sv | 171 +++++++++++++++++
 tb/tb_ddr_rd_return.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_rd_pkg.sv
// Shared types, widths and burst-length helper for the read-return stage.
// Imported by ddr_rd_return; sync_fifo is generic and needs nothing from it.
package ddr_rd_pkg;

    // Burst lengths when no page burst is selected.
    localparam int BL1 = 1;
    localparam int BL2 = 2;
    localparam int BL4 = 4;
    localparam int BL8 = 8;

    // Command queue entries hold (request beats - 1) so 1..1024 fits 10 bits.
    localparam int CMD_W = 10;
    // Full request beat total, 1..1024.
    localparam int REQ_W = 11;

    typedef enum logic {
        IDLE,
        ACTIVE
    } rd_state_t;

    // Beats in one read request. Priority: page, 8, 4, 2, then 1.
    function automatic logic [REQ_W-1:0] beats_per_req(
        input logic       burst_2,
        input logic       burst_4,
        input logic       burst_8,
        input logic       burst_p,
        input logic [1:0] req_len,
        input int         page_beats
    );
        logic [REQ_W-1:0] bl;
        logic [REQ_W-1:0] n;
        if (burst_p)      bl = REQ_W'(page_beats);
        else if (burst_8) bl = REQ_W'(BL8);
        else if (burst_4) bl = REQ_W'(BL4);
        else if (burst_2) bl = REQ_W'(BL2);
        else              bl = REQ_W'(BL1);
        n = REQ_W'(req_len) + 1'b1;
        return bl * n;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with push/pop, full/empty flags and an occupancy count.
// Ports: clk, rst, push, pop, din -> dout (head), full, empty, count.
module sync_fifo #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [W-1:0]         din,
    output logic [W-1:0]         dout,
    output logic                 full,
    output logic                 empty,
    output logic [$clog2(D):0]   count
);

    localparam int AW = $clog2(D);
    localparam logic [AW:0] FULL_CNT = D[AW:0];

    logic [W-1:0]  mem [D];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ddr_rd_return.sv
// Read-return stage: buffers data-path beats, frames requests, feeds host.
// Ports: rd_cmd/burst_*/req_len in, u_data_* in, h_rd_* out, status out.
module ddr_rd_return
    import ddr_rd_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 16,
    parameter int CMD_DEPTH  = 4,
    parameter int PAGE_BEATS = 256
) (
    input  logic                     clk,
    input  logic                     rst2,
    input  logic                     rd_cmd,
    input  logic                     burst_2,
    input  logic                     burst_4,
    input  logic                     burst_8,
    input  logic                     burst_p,
    input  logic [1:0]               req_len,
    input  logic [DATA_W-1:0]        u_data_o,
    input  logic                     u_data_valid,
    output logic [DATA_W-1:0]        h_rd_data,
    output logic                     h_rd_valid,
    output logic                     h_rd_last,
    input  logic                     h_rd_ready,
    output logic                     cmd_full,
    output logic [$clog2(DEPTH):0]   fifo_free,
    output logic                     err_ovf,
    output logic                     err_orphan,
    input  logic                     err_clr
);

    localparam int FW = $clog2(DEPTH) + 1;
    localparam logic [FW-1:0] FREE_RST = DEPTH[FW-1:0];

    rd_state_t        state;
    logic [CMD_W-1:0] remaining;

    logic [REQ_W-1:0] req_beats;
    logic [CMD_W-1:0] cmd_din;
    logic [CMD_W-1:0] cmd_head;
    logic             cmd_push;
    logic             cmd_pop;
    logic             cmd_empty;
    logic [$clog2(CMD_DEPTH):0] unused_cmd_cnt;

    logic [DATA_W:0]  d_head;
    logic             d_empty;
    logic             d_full;
    logic             wr;
    logic             wr_last;
    logic             wr_ok;
    logic             h_pop;
    logic             orphan;
    logic             ovf;
    logic [FW-1:0]    unused_d_cnt;

    assign req_beats = beats_per_req(burst_2, burst_4, burst_8,
                                     burst_p, req_len, PAGE_BEATS);
    assign cmd_din   = CMD_W'(req_beats - 1'b1);
    assign cmd_push  = rd_cmd & ~cmd_full;

    sync_fifo #(
        .W (CMD_W),
        .D (CMD_DEPTH)
    ) u_cmd_q (
        .clk   (clk),
        .rst   (rst2),
        .push  (cmd_push),
        .pop   (cmd_pop),
        .din   (cmd_din),
        .dout  (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (unused_cmd_cnt)
    );

    // Beat steering. cmd_head already holds (beats - 1).
    always_comb begin
        wr      = 1'b0;
        wr_last = 1'b0;
        cmd_pop = 1'b0;
        orphan  = 1'b0;
        if (u_data_valid) begin
            unique case (state)
                IDLE: begin
                    if (cmd_empty) begin
                        orphan = 1'b1;
                    end else begin
                        wr = 1'b1;
                        if (cmd_head == '0) begin
                            wr_last = 1'b1;
                            cmd_pop = 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    wr = 1'b1;
                    if (remaining == CMD_W'(1)) begin
                        wr_last = 1'b1;
                        cmd_pop = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst2) begin
            state     <= IDLE;
            remaining <= '0;
        end else if (u_data_valid) begin
            unique case (state)
                IDLE: begin
                    if (!cmd_empty) begin
                        remaining <= cmd_head;
                        if (cmd_head != '0) state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    remaining <= remaining - 1'b1;
                    if (remaining == CMD_W'(1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign h_rd_valid = ~d_empty;
    assign h_pop      = h_rd_valid & h_rd_ready;
    assign wr_ok      = wr & (~d_full | h_pop);
    // Dropped beats were still counted above, so framing survives.
    assign ovf        = wr & ~wr_ok;

    sync_fifo #(
        .W (DATA_W + 1),
        .D (DEPTH)
    ) u_data_q (
        .clk   (clk),
        .rst   (rst2),
        .push  (wr),
        .pop   (h_pop),
        .din   ({wr_last, u_data_o}),
        .dout  (d_head),
        .full  (d_full),
        .empty (d_empty),
        .count (unused_d_cnt)
    );

    // Mask the unreset storage so idle outputs read as zero.
    assign h_rd_data = h_rd_valid ? d_head[DATA_W-1:0] : '0;
    assign h_rd_last = h_rd_valid & d_head[DATA_W];

    always_ff @(posedge clk) begin
        if (rst2) begin
            fifo_free  <= FREE_RST;
            err_ovf    <= 1'b0;
            err_orphan <= 1'b0;
        end else begin
            case ({wr_ok, h_pop})
                2'b10:   fifo_free <= fifo_free - 1'b1;
                2'b01:   fifo_free <= fifo_free + 1'b1;
                default: fifo_free <= fifo_free;
            endcase
            // A new event in the clear cycle keeps the flag set.
            err_ovf    <= ovf | (err_ovf & ~err_clr);
            err_orphan <= orphan | (err_orphan & ~err_clr);
        end
    end

endmodule

// File: tb/tb_ddr_rd_return.sv
// Directed self-checking bench for ddr_rd_return.
// Drives after the rising edge, samples 1ns after each edge.
module tb_ddr_rd_return;

    logic        clk = 1'b0;
    logic        rst2;
    logic        rd_cmd;
    logic        burst_2;
    logic        burst_4;
    logic        burst_8;
    logic        burst_p;
    logic [1:0]  req_len;
    logic [31:0] u_data_o;
    logic        u_data_valid;
    logic [31:0] h_rd_data;
    logic        h_rd_valid;
    logic        h_rd_last;
    logic        h_rd_ready;
    logic        cmd_full;
    logic [4:0]  fifo_free;
    logic        err_ovf;
    logic        err_orphan;
    logic        err_clr;

    int checks = 0;
    int errors = 0;

    ddr_rd_return dut (
        .clk          (clk),
        .rst2         (rst2),
        .rd_cmd       (rd_cmd),
        .burst_2      (burst_2),
        .burst_4      (burst_4),
        .burst_8      (burst_8),
        .burst_p      (burst_p),
        .req_len      (req_len),
        .u_data_o     (u_data_o),
        .u_data_valid (u_data_valid),
        .h_rd_data    (h_rd_data),
        .h_rd_valid   (h_rd_valid),
        .h_rd_last    (h_rd_last),
        .h_rd_ready   (h_rd_ready),
        .cmd_full     (cmd_full),
        .fifo_free    (fifo_free),
        .err_ovf      (err_ovf),
        .err_orphan   (err_orphan),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic b2, input logic b4, input logic b8,
                       input logic bp, input logic [1:0] len);
        rd_cmd  = 1'b1;
        burst_2 = b2;
        burst_4 = b4;
        burst_8 = b8;
        burst_p = bp;
        req_len = len;
        tick();
        rd_cmd  = 1'b0;
        burst_2 = 1'b0;
        burst_4 = 1'b0;
        burst_8 = 1'b0;
        burst_p = 1'b0;
        req_len = 2'd0;
    endtask

    task automatic beat(input logic [31:0] d);
        u_data_valid = 1'b1;
        u_data_o     = d;
        tick();
        u_data_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        checks += 7;
        if (h_rd_valid !== 1'b0) begin errors++;
            $display("FAIL rst_valid got %b want 0", h_rd_valid); end
        if (h_rd_last !== 1'b0) begin errors++;
            $display("FAIL rst_last got %b want 0", h_rd_last); end
        if (h_rd_data !== 32'h0) begin errors++;
            $display("FAIL rst_data got %h want 0", h_rd_data); end
        if (cmd_full !== 1'b0) begin errors++;
            $display("FAIL rst_cmd_full got %b want 0", cmd_full); end
        if (fifo_free !== 5'd16) begin errors++;
            $display("FAIL rst_free got %0d want 16", fifo_free); end
        if (err_ovf !== 1'b0) begin errors++;
            $display("FAIL rst_ovf got %b want 0", err_ovf); end
        if (err_orphan !== 1'b0) begin errors++;
            $display("FAIL rst_orphan got %b want 0", err_orphan); end
    endtask

    task automatic test_bl4();
        h_rd_ready = 1'b1;
        cmd(0, 1, 0, 0, 2'd1);
        for (int i = 0; i < 8; i++) begin
            beat(32'h100 + i);
            checks += 2;
            if (h_rd_valid !== 1'b1 || h_rd_data !== 32'h100 + i) begin
                errors++;
                $display("FAIL bl4_data[%0d] got %b/%h want 1/%h",
                         i, h_rd_valid, h_rd_data, 32'h100 + i);
            end
            if (h_rd_last !== (i == 7)) begin errors++;
                $display("FAIL bl4_last[%0d] got %b want %b",
                         i, h_rd_last, i == 7); end
        end
        tick();
        checks += 2;
        if (h_rd_valid !== 1'b0) begin errors++;
            $display("FAIL bl4_drain got %b want 0", h_rd_valid); end
        if (fifo_free !== 5'd16) begin errors++;
            $display("FAIL bl4_free got %0d want 16", fifo_free); end
    endtask

    task automatic test_back_to_back();
        h_rd_ready = 1'b1;
        cmd(1, 0, 0, 0, 2'd0);
        cmd(0, 0, 1, 0, 2'd0);
        for (int i = 0; i < 10; i++) begin
            beat(32'h200 + i);
            checks += 3;
            if (h_rd_data !== 32'h200 + i) begin errors++;
                $display("FAIL b2b_data[%0d] got %h want %h",
                         i, h_rd_data, 32'h200 + i); end
            if (h_rd_last !== (i == 1 || i == 9)) begin errors++;
                $display("FAIL b2b_last[%0d] got %b want %b",
                         i, h_rd_last, i == 1 || i == 9); end
            if (cmd_full !== 1'b0) begin errors++;
                $display("FAIL b2b_cmd_full[%0d] got %b want 0",
                         i, cmd_full); end
        end
        tick();
    endtask

    task automatic test_priority();
        h_rd_ready = 1'b1;
        // burst_8 outranks burst_2
        cmd(1, 0, 1, 0, 2'd0);
        for (int i = 0; i < 8; i++) begin
            beat(32'h800 + i);
            checks++;
            if (h_rd_last !== (i == 7)) begin errors++;
                $display("FAIL prio8_last[%0d] got %b want %b",
                         i, h_rd_last, i == 7); end
        end
        // page burst outranks burst_4
        cmd(0, 1, 0, 1, 2'd0);
        for (int i = 0; i < 256; i++) begin
            beat(32'h900 + i);
            checks++;
            if (h_rd_last !== (i == 255)) begin errors++;
                $display("FAIL page_last[%0d] got %b want %b",
                         i, h_rd_last, i == 255); end
        end
        tick();
        checks++;
        if (h_rd_valid !== 1'b0) begin errors++;
            $display("FAIL page_drain got %b want 0", h_rd_valid); end
    endtask

    task automatic test_cmd_full();
        h_rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) cmd(0, 0, 0, 0, 2'd0);
        checks++;
        if (cmd_full !== 1'b1) begin errors++;
            $display("FAIL cmdq_full got %b want 1", cmd_full); end
        cmd(1, 0, 0, 0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            beat(32'hA00 + i);
            checks += 2;
            if (h_rd_last !== 1'b1) begin errors++;
                $display("FAIL cmdq_last[%0d] got %b want 1",
                         i, h_rd_last); end
            if (cmd_full !== 1'b0) begin errors++;
                $display("FAIL cmdq_after_pop[%0d] got %b want 0",
                         i, cmd_full); end
        end
        beat(32'hA04);
        checks++;
        if (err_orphan !== 1'b1) begin errors++;
            $display("FAIL cmdq_ignored got %b want 1", err_orphan); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_orphan();
        h_rd_ready = 1'b1;
        beat(32'hDEAD);
        checks += 3;
        if (err_orphan !== 1'b1) begin errors++;
            $display("FAIL orphan_flag got %b want 1", err_orphan); end
        if (h_rd_valid !== 1'b0) begin errors++;
            $display("FAIL orphan_valid got %b want 0", h_rd_valid); end
        if (fifo_free !== 5'd16) begin errors++;
            $display("FAIL orphan_free got %0d want 16", fifo_free); end
        tick();
        checks++;
        if (err_orphan !== 1'b1) begin errors++;
            $display("FAIL orphan_sticky got %b want 1", err_orphan); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_orphan !== 1'b0) begin errors++;
            $display("FAIL orphan_clr got %b want 0", err_orphan); end
        err_clr = 1'b1;
        beat(32'hBEEF);
        err_clr = 1'b0;
        checks++;
        if (err_orphan !== 1'b1) begin errors++;
            $display("FAIL orphan_clr_race got %b want 1", err_orphan); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_orphan !== 1'b0) begin errors++;
            $display("FAIL orphan_clr2 got %b want 0", err_orphan); end
    endtask

    task automatic test_overflow();
        h_rd_ready = 1'b0;
        cmd(0, 0, 1, 0, 2'd2);
        for (int i = 0; i < 24; i++) begin
            beat(32'h300 + i);
            checks += 3;
            if (fifo_free !== ((i < 16) ? 5'(15 - i) : 5'd0)) begin
                errors++;
                $display("FAIL ovf_free[%0d] got %0d want %0d", i,
                         fifo_free, (i < 16) ? 15 - i : 0);
            end
            if (err_ovf !== (i >= 16)) begin errors++;
                $display("FAIL ovf_flag[%0d] got %b want %b",
                         i, err_ovf, i >= 16); end
            if (h_rd_valid !== 1'b1 || h_rd_data !== 32'h300) begin
                errors++;
                $display("FAIL ovf_hold[%0d] got %b/%h want 1/300",
                         i, h_rd_valid, h_rd_data);
            end
        end
        h_rd_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            checks += 2;
            if (h_rd_data !== 32'h300 + j) begin errors++;
                $display("FAIL ovf_drain[%0d] got %h want %h",
                         j, h_rd_data, 32'h300 + j); end
            if (h_rd_last !== 1'b0) begin errors++;
                $display("FAIL ovf_drain_last[%0d] got %b want 0",
                         j, h_rd_last); end
            tick();
        end
        checks += 2;
        if (h_rd_valid !== 1'b0) begin errors++;
            $display("FAIL ovf_empty got %b want 0", h_rd_valid); end
        if (fifo_free !== 5'd16) begin errors++;
            $display("FAIL ovf_free_end got %0d want 16", fifo_free); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_ovf !== 1'b0) begin errors++;
            $display("FAIL ovf_clr got %b want 0", err_ovf); end
        cmd(1, 0, 0, 0, 2'd0);
        for (int i = 0; i < 2; i++) begin
            beat(32'h400 + i);
            checks++;
            if (h_rd_data !== 32'h400 + i || h_rd_last !== (i == 1)) begin
                errors++;
                $display("FAIL ovf_next[%0d] got %h/%b want %h/%b", i,
                         h_rd_data, h_rd_last, 32'h400 + i, i == 1);
            end
        end
        tick();
    endtask

    task automatic test_full_pushpop();
        h_rd_ready = 1'b0;
        cmd(0, 0, 1, 0, 2'd2);
        for (int i = 0; i < 16; i++) beat(32'h500 + i);
        checks++;
        if (fifo_free !== 5'd0) begin errors++;
            $display("FAIL pp_full got %0d want 0", fifo_free); end
        h_rd_ready = 1'b1;
        for (int k = 16; k < 24; k++) begin
            beat(32'h500 + k);
            checks += 3;
            if (fifo_free !== 5'd0) begin errors++;
                $display("FAIL pp_free[%0d] got %0d want 0", k, fifo_free); end
            if (err_ovf !== 1'b0) begin errors++;
                $display("FAIL pp_ovf[%0d] got %b want 0", k, err_ovf); end
            if (h_rd_data !== 32'h500 + k - 15) begin errors++;
                $display("FAIL pp_head[%0d] got %h want %h",
                         k, h_rd_data, 32'h500 + k - 15); end
        end
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (h_rd_data !== 32'h508 + j || h_rd_last !== (j == 15)) begin
                errors++;
                $display("FAIL pp_drain[%0d] got %h/%b want %h/%b", j,
                         h_rd_data, h_rd_last, 32'h508 + j, j == 15);
            end
            tick();
        end
        checks++;
        if (fifo_free !== 5'd16) begin errors++;
            $display("FAIL pp_free_end got %0d want 16", fifo_free); end
    endtask

    task automatic test_reset_mid();
        h_rd_ready = 1'b0;
        cmd(0, 0, 1, 0, 2'd0);
        for (int i = 0; i < 3; i++) beat(32'h600 + i);
        test_reset();
        h_rd_ready = 1'b1;
        cmd(0, 0, 0, 0, 2'd0);
        beat(32'h700);
        checks++;
        if (h_rd_valid !== 1'b1 || h_rd_data !== 32'h700 ||
            h_rd_last !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_bl1 got %b/%h/%b want 1/700/1",
                     h_rd_valid, h_rd_data, h_rd_last);
        end
        tick();
        checks += 2;
        if (h_rd_valid !== 1'b0) begin errors++;
            $display("FAIL rstmid_drain got %b want 0", h_rd_valid); end
        if (err_orphan !== 1'b0) begin errors++;
            $display("FAIL rstmid_orphan got %b want 0", err_orphan); end
    endtask

    initial begin
        rst2         = 1'b1;
        rd_cmd       = 1'b0;
        burst_2      = 1'b0;
        burst_4      = 1'b0;
        burst_8      = 1'b0;
        burst_p      = 1'b0;
        req_len      = 2'd0;
        u_data_o     = 32'h0;
        u_data_valid = 1'b0;
        h_rd_ready   = 1'b0;
        err_clr      = 1'b0;
        tick();
        test_reset();
        test_bl4();
        test_back_to_back();
        test_priority();
        test_cmd_full();
        test_orphan();
        test_overflow();
        test_full_pushpop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
